envelope_generator: RTL and testbench
=====================================

// Module: envelope_generator
// PURPOSE
//  ADSR amplitude envelope: turns a key gate into the time-varying max_amplitude (volume) that
//  drives the overdrive/clipping stage and the tone generator downstream of it.
//  Sits between keyboard/gate logic and the fx chain; one instance per voice.
// PARAMETERS
//  WIDTH        31      amplitude width; matches fx-chain amplitude buses
//  TICK_DIV     500     clk cycles per envelope tick (rate prescaler), >=1
//  ATTACK_STEP  2**21   level increment per tick in ATTACK
//  DECAY_STEP   2**19   level decrement per tick in DECAY
//  RELEASE_STEP 2**19   level decrement per tick in RELEASE
// PORTS
//  clk            in   1      system clock
//  reset          in   1      async, active-high
//  gate           in   1      1 = key held; sampled on tick only
//  peak           in   WIDTH  attack target level
//  sustain_level  in   WIDTH  sustain level; clamped to peak internally
//  max_amplitude  out  WIDTH  registered envelope level
//  threshold      out  WIDTH  positive clip level for overdrive stage
//  neg_threshold  out  WIDTH  negative clip level for overdrive stage
//  state          out  3      current ADSR state code
//  active         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: max_amplitude=0, state=IDLE, active=0, prescaler=0, threshold/neg_threshold per
//    CONFIGURATION with level 0. Reset mid-envelope aborts immediately, no ramp-down.
//  - Prescaler counts 0..TICK_DIV-1; tick = 1-cycle pulse at wrap. All state/level updates occur
//    only on the tick cycle; outputs change on the clock edge ending the tick cycle
//    (latency 1 clk from tick).
//  - sus = min(sustain_level, peak), evaluated each tick.
//  - IDLE: gate=1 -> ATTACK (level unchanged that tick).
//  - ATTACK: gate=0 -> RELEASE; else level += ATTACK_STEP, saturating at peak;
//    on reaching peak -> DECAY.
//  - DECAY: gate=0 -> RELEASE; else level -= DECAY_STEP, floored at sus;
//    on reaching sus -> SUSTAIN.
//  - SUSTAIN: gate=0 -> RELEASE; else level tracks sus directly
//    (peak/sustain changes apply next tick).
//  - RELEASE: gate=1 -> ATTACK from current level (retrigger, no reset to 0);
//    else level -= RELEASE_STEP, floored at 0; on reaching 0 -> IDLE.
//  - Gate release has priority over every level update on the same tick.
//  - Arithmetic in WIDTH+1 bits, then clamp: no wrap-around past peak or below 0/sus.
//  - peak=0: ATTACK reaches peak on the first update tick -> DECAY -> SUSTAIN at 0.
//  - Gate pulses shorter than TICK_DIV that miss a tick are ignored by design.
//  - State codes: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4.
// CONFIGURATION
//  THRESHOLD_TRACK_EN defined: threshold = level - (level>>2), neg_threshold = level>>2,
//    registered with max_amplitude (same cycle); clip point follows the envelope.
//  Not defined: threshold = peak - (peak>>2), neg_threshold = peak>>2, registered each clk
//    (1-clk latency from peak), independent of the envelope level.
// STRUCTURE
//  - Shared package/include synth_defs: ADSR state code localparams, WIDTH default.
//  - Sub-module rate_divider (TICK_DIV, clk, reset -> tick); same async active-high reset.
//  - Remainder: one FSM always block plus one level/threshold register block.
// TESTING
//  1. TICK_DIV=1, peak=1000, sus=400, ATTACK_STEP=300, DECAY_STEP=200: gate=1 ->
//     levels 0,300,600,900,1000 (DECAY),800,600,400 (SUSTAIN).
//  2. In SUSTAIN at 400, gate=0, RELEASE_STEP=150 -> 250,100,0, then IDLE, active=0.
//  3. Retrigger: gate=1 while RELEASE level=250 -> ATTACK from 250: 550,850,1000.
//  4. sustain_level=2000 > peak=1000 -> DECAY ends at 1000 immediately, no underflow.
//  5. TICK_DIV=4: level changes exactly every 4 clk; 2-clk gate pulse between ticks is ignored.
//  6. Assert reset mid-ATTACK (level=600): same-cycle async clear to 0/IDLE.
//     With THRESHOLD_TRACK_EN at level 1000: threshold=750, neg_threshold=250.

Source files
------------

// File: rtl/synth_defs_pkg.sv
// Shared definitions for the voice envelope path: ADSR state codes and default widths.
package synth_defs_pkg;

  localparam int unsigned WIDTH_DEFAULT = 31;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/rate_divider.sv
// Envelope rate prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on the wrap cycle.
module rate_divider #(
  parameter int unsigned TICK_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q is precomputed so it is high exactly while cnt_q sits at LAST
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/envelope_generator.sv
// ADSR amplitude envelope for one voice. Define THRESHOLD_TRACK_EN to make the overdrive
// clip thresholds follow the envelope level instead of the peak setting.
module envelope_generator
  import synth_defs_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEFAULT,
  parameter int unsigned TICK_DIV     = 500,
  parameter int unsigned ATTACK_STEP  = 2**21,
  parameter int unsigned DECAY_STEP   = 2**19,
  parameter int unsigned RELEASE_STEP = 2**19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gate,
  input  logic [WIDTH-1:0]   peak,
  input  logic [WIDTH-1:0]   sustain_level,
  output logic [WIDTH-1:0]   max_amplitude,
  output logic [WIDTH-1:0]   threshold,
  output logic [WIDTH-1:0]   neg_threshold,
  output logic [STATE_W-1:0] state,
  output logic               active
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [EXT_W-1:0] ATK_X = EXT_W'(ATTACK_STEP);
  localparam logic [EXT_W-1:0] DEC_X = EXT_W'(DECAY_STEP);
  localparam logic [EXT_W-1:0] REL_X = EXT_W'(RELEASE_STEP);

  logic tick;

  rate_divider #(.TICK_DIV(TICK_DIV)) u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  adsr_state_e      state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] sus;
  logic [EXT_W-1:0] lvl_x, peak_x, sus_x;

  // Next state and level; the one-bit headroom keeps step arithmetic from wrapping
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    sus     = (sustain_level < peak) ? sustain_level : peak;
    lvl_x   = {1'b0, level_q};
    peak_x  = {1'b0, peak};
    sus_x   = {1'b0, sus};
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (gate) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else if (lvl_x + ATK_X >= peak_x) begin
            level_d = peak;
            state_d = ST_DECAY;
          end else begin
            level_d = WIDTH'(lvl_x + ATK_X);
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else if (lvl_x <= sus_x + DEC_X) begin
            level_d = sus;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = WIDTH'(lvl_x - DEC_X);
          end
        end
        ST_SUSTAIN: begin
          if (!gate) state_d = ST_RELEASE;
          else       level_d = sus;
        end
        ST_RELEASE: begin
          if (gate) begin
            state_d = ST_ATTACK;
          end else if (lvl_x <= REL_X) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = WIDTH'(lvl_x - REL_X);
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_comb begin
`ifdef THRESHOLD_TRACK_EN
    thr_d = level_d - (level_d >> 2);
    neg_d = level_d >> 2;
`else
    thr_d = peak - (peak >> 2);
    neg_d = peak >> 2;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      thr_q   <= '0;
      neg_q   <= '0;
    end else begin
      level_q <= level_d;
      thr_q   <= thr_d;
      neg_q   <= neg_d;
    end
  end

  assign max_amplitude = level_q;
  assign threshold     = thr_q;
  assign neg_threshold = neg_q;
  assign state         = state_q;
  assign active        = active_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Bench for envelope_generator: directed vector table, multi-cycle corner sequences,
// and randomized gate/peak/sustain traffic against an arithmetic ADSR model.
module tb_envelope_generator;

  localparam int     W  = 31;
  localparam longint AS = 300;
  localparam longint DS = 200;
  localparam longint RS = 150;

  logic         clk = 1'b0;
  logic         reset;
  logic         gate, gate4;
  logic [W-1:0] peak, sus_lvl, peak4, sus4;
  logic [W-1:0] amp, thr, nthr, amp4, thr4, nthr4;
  logic [2:0]   st, st4;
  logic         act, act4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  envelope_generator #(.WIDTH(W), .TICK_DIV(1), .ATTACK_STEP(300), .DECAY_STEP(200),
                       .RELEASE_STEP(150)) dut (
    .clk(clk), .reset(reset), .gate(gate), .peak(peak), .sustain_level(sus_lvl),
    .max_amplitude(amp), .threshold(thr), .neg_threshold(nthr), .state(st), .active(act)
  );

  envelope_generator #(.WIDTH(W), .TICK_DIV(4), .ATTACK_STEP(300), .DECAY_STEP(200),
                       .RELEASE_STEP(150)) dut4 (
    .clk(clk), .reset(reset), .gate(gate4), .peak(peak4), .sustain_level(sus4),
    .max_amplitude(amp4), .threshold(thr4), .neg_threshold(nthr4), .state(st4), .active(act4)
  );

  typedef struct {
    logic   g;
    longint pk;
    longint sl;
    longint lvl;
    int     st;
  } vec_t;

  vec_t vecs[$];

  // Reference model: ADSR rules in plain signed arithmetic, one call per tick
  int     m_state;
  longint m_lvl;

  function automatic void model_tick(input logic g, input longint pk, input longint sl);
    longint s;
    s = (sl < pk) ? sl : pk;
    case (m_state)
      0: if (g) m_state = 1;
      1: if (!g) m_state = 4;
         else begin
           m_lvl = m_lvl + AS;
           if (m_lvl >= pk) begin m_lvl = pk; m_state = 2; end
         end
      2: if (!g) m_state = 4;
         else begin
           m_lvl = m_lvl - DS;
           if (m_lvl <= s) begin m_lvl = s; m_state = 3; end
         end
      3: if (!g) m_state = 4;
         else m_lvl = s;
      default: if (g) m_state = 1;
         else begin
           m_lvl = m_lvl - RS;
           if (m_lvl <= 0) begin m_lvl = 0; m_state = 0; end
         end
    endcase
  endfunction

  function automatic logic [63:0] exp_thr(input longint lvl, input longint pk);
`ifdef THRESHOLD_TRACK_EN
    return 64'(lvl - lvl / 4);
`else
    return 64'(pk - pk / 4);
`endif
  endfunction

  function automatic logic [63:0] exp_neg(input longint lvl, input longint pk);
`ifdef THRESHOLD_TRACK_EN
    return 64'(lvl / 4);
`else
    return 64'(pk / 4);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
  endtask

  task automatic check_main(input string name, input longint lvl, input int s, input longint pk);
    check({name, ".level"}, 64'(amp), 64'(lvl));
    check({name, ".state"}, 64'(st), 64'(s));
    check({name, ".active"}, 64'(act), 64'(s != 0));
    check({name, ".thr"}, 64'(thr), exp_thr(lvl, pk));
    check({name, ".neg"}, 64'(nthr), exp_neg(lvl, pk));
  endtask

  task automatic check_cleared(input string name);
    check({name, ".level"}, 64'(amp), 64'd0);
    check({name, ".state"}, 64'(st), 64'd0);
    check({name, ".active"}, 64'(act), 64'd0);
    check({name, ".thr"}, 64'(thr), 64'd0);
    check({name, ".neg"}, 64'(nthr), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    gate = 1'b0; gate4 = 1'b0;
    #1 check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step_main(input logic g, input longint pk, input longint sl);
    gate = g; peak = W'(pk); sus_lvl = W'(sl);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void add(input logic g, input longint pk, input longint sl,
                              input longint lvl, input int s);
    vec_t v;
    v.g = g; v.pk = pk; v.sl = sl; v.lvl = lvl; v.st = s;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    gate = 1'b0; gate4 = 1'b0;
    peak = '0; sus_lvl = '0; peak4 = '0; sus4 = '0;

    // Attack/decay to sustain, release to idle, retrigger from release, sustain clamping
    add(1, 1000, 400,    0, 1); add(1, 1000, 400,  300, 1); add(1, 1000, 400,  600, 1);
    add(1, 1000, 400,  900, 1); add(1, 1000, 400, 1000, 2); add(1, 1000, 400,  800, 2);
    add(1, 1000, 400,  600, 2); add(1, 1000, 400,  400, 3); add(1, 1000, 400,  400, 3);
    add(0, 1000, 400,  400, 4); add(0, 1000, 400,  250, 4); add(0, 1000, 400,  100, 4);
    add(0, 1000, 400,    0, 0); add(0, 1000, 400,    0, 0);
    add(1, 1000, 400,    0, 1); add(1, 1000, 400,  300, 1); add(1, 1000, 400,  600, 1);
    add(1, 1000, 400,  900, 1); add(1, 1000, 400, 1000, 2); add(1, 1000, 400,  800, 2);
    add(1, 1000, 400,  600, 2); add(1, 1000, 400,  400, 3);
    add(0, 1000, 400,  400, 4); add(0, 1000, 400,  250, 4);
    add(1, 1000, 400,  250, 1); add(1, 1000, 400,  550, 1); add(1, 1000, 400,  850, 1);
    add(1, 1000, 400, 1000, 2);
    add(1, 1000, 2000, 1000, 3); add(1, 1000, 2000, 1000, 3);
    add(1, 1000, 400,  400, 3); add(1, 300, 400,   300, 3);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step_main(vecs[i].g, vecs[i].pk, vecs[i].sl);
      check_main($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].st, vecs[i].pk);
    end

    // Asynchronous reset in the middle of ATTACK
    do_reset();
    step_main(1, 1000, 400);
    step_main(1, 1000, 400);
    step_main(1, 1000, 400);
    check_main("pre_abort", 600, 1, 1000);
    #2 reset = 1'b1;
    #1 check_cleared("abort");
    @(negedge clk);
    reset = 1'b0;

    // peak = 0 walks straight through DECAY into SUSTAIN at 0
    step_main(1, 0, 400);
    check_main("pk0_a", 0, 1, 0);
    step_main(1, 0, 400);
    check_main("pk0_d", 0, 2, 0);
    step_main(1, 0, 400);
    check_main("pk0_s", 0, 3, 0);

    // Prescaled instance: short gate pulse missing a tick, then level steps every 4 clk
    do_reset();
    gate = 1'b0;
    peak4 = W'(1000); sus4 = W'(400);
    gate4 = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    gate4 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("div4_pulse.state", 64'(st4), 64'd0);
    check("div4_pulse.level", 64'(amp4), 64'd0);
    gate4 = 1'b1;
    for (int e = 5; e <= 16; e++) begin
      longint el;
      int     es;
      @(posedge clk); @(negedge clk);
      es = (e >= 8) ? 1 : 0;
      el = (e >= 16) ? 600 : (e >= 12) ? 300 : 0;
      check($sformatf("div4_e%0d.state", e), 64'(st4), 64'(es));
      check($sformatf("div4_e%0d.level", e), 64'(amp4), 64'(el));
      check($sformatf("div4_e%0d.active", e), 64'(act4), 64'(es != 0));
      check($sformatf("div4_e%0d.thr", e), 64'(thr4), exp_thr(el, 1000));
    end
    gate4 = 1'b0;

    // Randomized traffic against the model
    do_reset();
    m_state = 0; m_lvl = 0;
    begin
      logic   g;
      longint pk, sl;
      g = 1'b0; pk = 2000; sl = 700;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 24) == 0) g = ~g;
        if ($urandom_range(0, 199) == 0) pk = longint'($urandom_range(0, 5000));
        if ($urandom_range(0, 149) == 0) sl = longint'($urandom_range(0, 6000));
        if ($urandom_range(0, 599) == 0) begin
          #2 reset = 1'b1;
          #1 check_cleared($sformatf("rnd_rst%0d", c));
          @(negedge clk);
          reset = 1'b0;
          m_state = 0; m_lvl = 0;
        end
        model_tick(g, pk, sl);
        step_main(g, pk, sl);
        check_main($sformatf("rnd%0d", c), m_lvl, m_state, pk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
